// File: rtl/tcb_lib_demultiplexer_if.sv
// TCB point-to-point bus: request (vld/wen/adr/ben/wdt) and response (rdy/rdt/err).
interface tcb_if #(
  parameter int unsigned ABW = 32,
  parameter int unsigned DBW = 32,
  parameter int unsigned BEW = DBW/8
) ();
  logic           vld;
  logic           wen;
  logic [ABW-1:0] adr;
  logic [BEW-1:0] ben;
  logic [DBW-1:0] wdt;
  logic           rdy;
  logic [DBW-1:0] rdt;
  logic           err;

  modport man (output vld, wen, adr, ben, wdt, input  rdy, rdt, err);
  modport sub (input  vld, wen, adr, ben, wdt, output rdy, rdt, err);
endinterface

// File: rtl/tcb_lib_demultiplexer.sv
// TCB 1-to-PN demultiplexer: combinational request steering, DLY-delayed response mux.
// Optional TCB_LIB_DEMULTIPLEXER_ERR_EN terminates out-of-range selects locally with err=1.
module tcb_lib_demultiplexer #(
  parameter  int unsigned ABW = 32,
  parameter  int unsigned DBW = 32,
  parameter  int unsigned BEW = DBW/8,
  parameter  int unsigned DLY = 1,
  parameter  int unsigned PN  = 2,
  localparam int unsigned PL  = $clog2(PN)
) (
  input  logic          clk,
  input  logic          rst_n,
  tcb_if.sub            sub,
  input  logic [PL-1:0] sel,
  tcb_if.man            man [PN]
);

  logic           man_rdy [PN];
  logic [DBW-1:0] man_rdt [PN];
  logic           man_err [PN];

  logic           sel_ok;
  logic [PL-1:0]  sel_idx;
  logic           rdy;
  logic           trn;
  logic           oor_trn;

  logic           rsp_trn;
  logic [PL-1:0]  rsp_sel;
  logic           rsp_oor;
  logic [DBW-1:0] rsp_rdt;
  logic           rsp_err;

  // out-of-range selects index port 0 so the muxes never see an X index
  assign sel_ok  = (32'(sel) < PN);
  assign sel_idx = sel_ok ? sel : '0;

  for (genvar i = 0; i < PN; i++) begin : g_man
    assign man[i].vld = sub.vld & (sel == PL'(i));
    assign man[i].wen = sub.wen;
    assign man[i].adr = sub.adr;
    assign man[i].ben = sub.ben;
    assign man[i].wdt = sub.wdt;
    assign man_rdy[i] = man[i].rdy;
    assign man_rdt[i] = man[i].rdt;
    assign man_err[i] = man[i].err;
  end

`ifdef TCB_LIB_DEMULTIPLEXER_ERR_EN
  assign rdy     = sel_ok ? man_rdy[sel_idx] : 1'b1;
  assign oor_trn = sub.vld & ~sel_ok;
`else
  assign rdy     = sel_ok & man_rdy[sel_idx];
  assign oor_trn = 1'b0;
`endif

  assign sub.rdy = rdy;
  assign trn     = sub.vld & rdy;

  if (DLY == 0) begin : g_dly0
    assign rsp_trn = trn;
    assign rsp_sel = sel_idx;
    assign rsp_oor = oor_trn;
  end else begin : g_dly
    logic [DLY:1]  trn_dly;
    logic [PL-1:0] sel_dly [DLY:1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        trn_dly <= '0;
        for (int unsigned k = 1; k <= DLY; k++) sel_dly[k] <= '0;
      end else begin
        trn_dly[1] <= trn;
        sel_dly[1] <= sel_idx;
        for (int unsigned k = 2; k <= DLY; k++) begin
          trn_dly[k] <= trn_dly[k-1];
          sel_dly[k] <= sel_dly[k-1];
        end
      end
    end

    assign rsp_trn = trn_dly[DLY];
    assign rsp_sel = sel_dly[DLY];

`ifdef TCB_LIB_DEMULTIPLEXER_ERR_EN
    logic [DLY:1] err_dly;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        err_dly <= '0;
      end else begin
        err_dly[1] <= oor_trn;
        for (int unsigned k = 2; k <= DLY; k++) err_dly[k] <= err_dly[k-1];
      end
    end

    assign rsp_oor = err_dly[DLY];
`else
    logic unused_oor;
    assign unused_oor = oor_trn;
    assign rsp_oor    = 1'b0;
`endif
  end

  // idle cycles drive defined zeros instead of whatever port 0 returns
  always_comb begin
    rsp_rdt = '0;
    rsp_err = 1'b0;
    if (rsp_trn) begin
      if (rsp_oor) begin
        rsp_err = 1'b1;
      end else begin
        rsp_rdt = man_rdt[rsp_sel];
        rsp_err = man_err[rsp_sel];
      end
    end
  end

  assign sub.rdt = rsp_rdt;
  assign sub.err = rsp_err;

endmodule
